tone_detector: RTL and testbench
================================

# tone_detector

Measures the period of an incoming square-wave tone and decodes it into one of the four keyboard notes: note 1 = 152 ticks, note 2 = 136, note 3 = 121, note 4 = 115 (one tick = 1/20 kHz).
- Receive-side counterpart of the piano tone generator: sits behind a speaker-line tap or microphone comparator.
- Drives the board LEDs with the note it hears.
- Runs on the board clock with a 20 kHz sampling tick derived internally.

## Interface
- CLK_DIV, 2500: CLK cycles per sampling tick; tick asserts when prescaler == CLK_DIV-1.
- TOL, 2: accepted ± deviation, in ticks, from a nominal note period.
- MATCH_CNT, 2: consecutive equal classifications required to change NOTE (1..7).
- TIMEOUT, 200: ticks without a rising edge before the detector drops to silence (≤ 255).
- CLK  in  1  system clock, M9 pin.
- RST_N  in  1  synchronous reset, active low; only sampled on the rising edge of CLK.
- ToneIn  in  1  asynchronous square-wave input.
- NOTE  out  3  0 = none, 1..4 = detected note.
- NOTE_VALID  out  1  high when NOTE != 0.
- NOTE_CHG  out  1  one-CLK pulse whenever NOTE changes value.
- LED0..LED3  out  1 each  one-hot of NOTE (LED0 = note 1); all low when NOTE = 0.
- LED4  out  1  synchronized ToneIn (activity monitor).

## Operation
- **Input synchronizer:** ToneIn passes through two flops on every CLK.
- **Prescaler:** counts 0..CLK_DIV-1 and wraps. All logic below updates only in tick cycles.
- **Edge detect:** `prev <= sync` each tick. A rising edge is `sync & ~prev` in a tick cycle.
- **Period counter PER (8 bit):**
  - Increments each tick and saturates at 255.
  - On an edge tick, the measured period is P = PER+1 (9-bit add, no wrap), then PER <= 0.
- **Classify P:**
  - c = 1 if |P-152| ≤ TOL; else 2 if |P-136| ≤ TOL; else 3 if |P-121| ≤ TOL; else 4 if |P-115| ≤ TOL; else 0.
  - Overlapping windows resolve in that priority order.
- **States:**
  - **IDLE:** no reference edge.
    - First edge → TRACK, PER <= 0.
    - No classification is made on this edge.
  - **TRACK:** on each edge, compute c.
    - If c == cand: run <= min(run+1, 7). Otherwise: cand <= c, run <= 1.
    - When the updated run == MATCH_CNT and cand != NOTE: NOTE <= cand, pulse NOTE_CHG.
    - cand = 0 reaching MATCH_CNT therefore clears NOTE (off-table tone).
    - If PER reaches TIMEOUT on a tick: → IDLE, NOTE <= 0, cand <= 0, run <= 0, PER <= 0. NOTE_CHG pulses if NOTE was nonzero.
- **Steady tone:** a continued matching tone keeps run saturated and produces no further NOTE_CHG pulses.
- **Priority:** an edge and a timeout in the same tick cannot coincide; the edge zeroes PER first.
- **Outputs:** NOTE_VALID and LED0..LED3 decode combinationally from the NOTE register.

## Timing
- **Reset values:** NOTE = 0, NOTE_VALID = 0, NOTE_CHG = 0, LED0..LED3 = 0. prescaler, PER, cand, run, prev = 0; state = IDLE; sync flops = 0, so LED4 = 0.
- **Reset mid-operation:** reset in any state or mid-tick returns all registers to reset values on the next CLK edge. The prescaler restarts at 0.
- **Input latency:** 2 CLK from ToneIn to sync, plus up to CLK_DIV CLK to the next tick.
- **NOTE latency:** NOTE and NOTE_CHG update on the CLK edge ending the tick cycle of the qualifying edge. NOTE_CHG is high for exactly the following CLK cycle.
- **Acquisition time:** from the first edge of a steady tone to NOTE = 1 is MATCH_CNT+1 rising edges, i.e. MATCH_CNT periods after the first edge.
- **Silence detection:** NOTE clears TIMEOUT ticks after the last rising edge.
- **Tick spacing:** one tick every CLK_DIV CLK cycles, with no jitter.

## Test plan
Unless noted, benches use CLK_DIV = 4, TOL = 2, MATCH_CNT = 2, TIMEOUT = 200.
- **Reset:** hold RST_N low 10 CLK with ToneIn toggling → all outputs 0. Release with ToneIn held low for 300 ticks → outputs stay 0, no NOTE_CHG.
- **Lock on note 1:** square wave, period 152 ticks (76 high / 76 low), 4 periods.
  - After the 3rd rising edge: NOTE = 1, LED0 = 1, NOTE_VALID = 1, NOTE_CHG pulses once.
  - The 4th edge produces no pulse.
- **Tolerance boundary:** periods of 138 ticks → NOTE = 2. Periods of 139 ticks → NOTE stays 0 (c = 0).
- **Note change and overlap:** lock on 121 (NOTE = 3), then switch to 115.
  - NOTE stays 3 after the first 115 period and becomes 4 after the second.
  - A 118-tick period classifies as 3 (priority rule).
- **Timeout:** lock on note 2, then hold ToneIn low → NOTE = 0 exactly 200 ticks after the last rising edge, with one NOTE_CHG pulse. The next tone re-acquires from IDLE.
- **Mid-lock reset:** lock on note 4, assert RST_N for 1 CLK → next CLK shows NOTE = 0 and LED3 = 0. Re-acquisition needs 3 fresh edges.

Source files
------------

// File: rtl/tone_detector_if.sv
// Pin bundle of the tone detector: the raw tone input plus the decoded note,
// its qualifiers and the board LEDs.
interface tone_detector_if;
    logic       ToneIn;
    logic [2:0] NOTE;
    logic       NOTE_VALID;
    logic       NOTE_CHG;
    logic       LED0;
    logic       LED1;
    logic       LED2;
    logic       LED3;
    logic       LED4;

    modport master (
        output ToneIn,
        input  NOTE, NOTE_VALID, NOTE_CHG, LED0, LED1, LED2, LED3, LED4
    );

    modport slave (
        input  ToneIn,
        output NOTE, NOTE_VALID, NOTE_CHG, LED0, LED1, LED2, LED3, LED4
    );
endinterface

// File: rtl/tone_detector.sv
// Measures the period of a square-wave tone in 20 kHz ticks and decodes it into
// one of four keyboard notes, requiring MATCH_CNT agreeing periods before NOTE moves.
module tone_detector #(
    parameter int CLK_DIV   = 2500,
    parameter int TOL       = 2,
    parameter int MATCH_CNT = 2,
    parameter int TIMEOUT   = 200
) (
    input  logic             CLK,
    input  logic             RST_N,
    tone_detector_if.slave   bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    function automatic logic near(input logic [8:0] p, input logic [8:0] nom);
        logic [8:0] diff;
        diff = (p > nom) ? (p - nom) : (nom - p);
        return (diff <= 9'(TOL));
    endfunction

    // Windows are tested in note order so an overlap resolves to the lower note number.
    function automatic logic [2:0] classify(input logic [8:0] p);
        logic [2:0] c;
        if (near(p, 9'd152))      c = 3'd1;
        else if (near(p, 9'd136)) c = 3'd2;
        else if (near(p, 9'd121)) c = 3'd3;
        else if (near(p, 9'd115)) c = 3'd4;
        else                      c = 3'd0;
        return c;
    endfunction

    logic          sync_a_r, sync_b_r;
    logic          prev_r, prev_nxt_s;
    logic [PW-1:0] presc_r, presc_nxt_s;
    logic [7:0]    per_r, per_nxt_s, per_inc_s;
    logic [2:0]    cand_r, cand_nxt_s;
    logic [2:0]    run_r, run_nxt_s, run_upd_s;
    logic [2:0]    note_r, note_nxt_s;
    logic          chg_r, chg_nxt_s;
    state_t        state_r, state_nxt_s;
    logic          tick_s, edge_s;
    logic [8:0]    period_s;
    logic [2:0]    class_s;

    assign tick_s    = (presc_r == PW'(CLK_DIV - 1));
    assign edge_s    = tick_s & sync_b_r & ~prev_r;
    assign period_s  = {1'b0, per_r} + 9'd1;
    assign class_s   = classify(period_s);
    assign per_inc_s = (per_r == 8'd255) ? 8'd255 : (per_r + 8'd1);
    assign run_upd_s = (class_s != cand_r) ? 3'd1 :
                       ((run_r == 3'd7) ? 3'd7 : (run_r + 3'd1));

    // Two-flop synchronizer for the asynchronous tone input.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_a_r <= 1'b0;
            sync_b_r <= 1'b0;
        end else begin
            sync_a_r <= bus.ToneIn;
            sync_b_r <= sync_a_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
            presc_r <= {PW{1'b0}};
            prev_r  <= 1'b0;
            per_r   <= 8'd0;
            cand_r  <= 3'd0;
            run_r   <= 3'd0;
            note_r  <= 3'd0;
            chg_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
            prev_r  <= prev_nxt_s;
            per_r   <= per_nxt_s;
            cand_r  <= cand_nxt_s;
            run_r   <= run_nxt_s;
            note_r  <= note_nxt_s;
            chg_r   <= chg_nxt_s;
        end
    end

    // Next-state logic; everything except the prescaler only moves in tick cycles.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = tick_s ? {PW{1'b0}} : (presc_r + {{(PW-1){1'b0}}, 1'b1});
        prev_nxt_s  = prev_r;
        per_nxt_s   = per_r;
        cand_nxt_s  = cand_r;
        run_nxt_s   = run_r;
        note_nxt_s  = note_r;
        chg_nxt_s   = 1'b0;
        if (tick_s) begin
            prev_nxt_s = sync_b_r;
            case (state_r)
                IDLE: begin
                    if (edge_s) begin
                        state_nxt_s = TRACK;
                        per_nxt_s   = 8'd0;
                    end else begin
                        per_nxt_s   = per_inc_s;
                    end
                end
                TRACK: begin
                    if (edge_s) begin
                        per_nxt_s  = 8'd0;
                        cand_nxt_s = class_s;
                        run_nxt_s  = run_upd_s;
                        if ((run_upd_s == 3'(MATCH_CNT)) && (class_s != note_r)) begin
                            note_nxt_s = class_s;
                            chg_nxt_s  = 1'b1;
                        end else begin
                            note_nxt_s = note_r;
                        end
                    end else if (per_inc_s == 8'(TIMEOUT)) begin
                        // Silence: forget the tone entirely and wait for a fresh reference edge.
                        state_nxt_s = IDLE;
                        per_nxt_s   = 8'd0;
                        cand_nxt_s  = 3'd0;
                        run_nxt_s   = 3'd0;
                        note_nxt_s  = 3'd0;
                        chg_nxt_s   = (note_r != 3'd0);
                    end else begin
                        per_nxt_s   = per_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            prev_nxt_s = prev_r;
        end
    end

    assign bus.NOTE       = note_r;
    assign bus.NOTE_CHG   = chg_r;
    assign bus.NOTE_VALID = (note_r != 3'd0);
    assign bus.LED0       = (note_r == 3'd1);
    assign bus.LED1       = (note_r == 3'd2);
    assign bus.LED2       = (note_r == 3'd3);
    assign bus.LED3       = (note_r == 3'd4);
    assign bus.LED4       = sync_b_r;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: a table of tone periods with hand-computed
// notes, plus sequences for reset, timeout and mid-lock reset.
module tb_tone_detector;

    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 200;

    typedef struct {
        int len;
        int exp_note;
        int exp_chg;
        int exp_note3;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic tone = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   chg_cnt = 0;
    int   cyc = 0;
    int   last_chg_cyc = 0;
    int   chg_base;
    int   t_lock;
    vec_t tbl [20];

    tone_detector_if bus ();
    tone_detector_if bus3 ();

    assign bus.ToneIn  = tone;
    assign bus3.ToneIn = tone;

    tone_detector #(.CLK_DIV(CLK_DIV), .TOL(2), .MATCH_CNT(2), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Wider tolerance makes the note-3 and note-4 windows overlap at 118.
    tone_detector #(.CLK_DIV(CLK_DIV), .TOL(3), .MATCH_CNT(2), .TIMEOUT(TIMEOUT)) dut3 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus3)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.NOTE_CHG === 1'b1) begin
            chg_cnt      <= chg_cnt + 1;
            last_chg_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * CLK_DIV) @(posedge CLK);
        #1;
    endtask

    task automatic period(input int len);
        tone = 1'b1;
        wait_ticks(len / 2);
        tone = 1'b0;
        wait_ticks(len - len / 2);
    endtask

    function automatic int led_exp(input int note);
        return (note == 0) ? 0 : (16 | (1 << (note - 1)));
    endfunction

    function automatic int led_act();
        return {27'd0, bus.NOTE_VALID, bus.LED3, bus.LED2, bus.LED1, bus.LED0};
    endfunction

    initial begin
        tbl[0]  = '{152, 0, 0, 0};
        tbl[1]  = '{152, 0, 0, 0};
        tbl[2]  = '{152, 1, 1, 1};
        tbl[3]  = '{152, 1, 0, 1};
        tbl[4]  = '{138, 1, 0, 1};
        tbl[5]  = '{138, 1, 0, 1};
        tbl[6]  = '{138, 2, 1, 2};
        tbl[7]  = '{139, 2, 0, 2};
        tbl[8]  = '{139, 2, 0, 2};
        tbl[9]  = '{139, 0, 1, 2};
        tbl[10] = '{139, 0, 0, 2};
        tbl[11] = '{121, 0, 0, 2};
        tbl[12] = '{121, 0, 0, 2};
        tbl[13] = '{121, 3, 1, 3};
        tbl[14] = '{115, 3, 0, 3};
        tbl[15] = '{115, 3, 0, 3};
        tbl[16] = '{115, 4, 1, 4};
        tbl[17] = '{118, 4, 0, 4};
        tbl[18] = '{118, 4, 0, 4};
        tbl[19] = '{118, 0, 1, 3};

        // Reset held with a toggling input, then 300 ticks of silence.
        RST_N = 1'b0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            tone = ~tone;
        end
        chk("reset_outputs",
            {24'd0, bus.NOTE, bus.NOTE_VALID, bus.NOTE_CHG, bus.LED0, bus.LED1, bus.LED2, bus.LED3, bus.LED4}, 0);
        tone  = 1'b0;
        RST_N = 1'b1;
        wait_ticks(300);
        chk("idle_note", bus.NOTE, 0);
        chk("idle_leds", led_act(), 0);
        chk("idle_led4", bus.LED4, 0);
        chk("idle_chg_count", chg_cnt, 0);

        for (int i = 0; i < 20; i++) begin
            chg_base = chg_cnt;
            tone = 1'b1;
            wait_ticks(tbl[i].len / 2);
            chk($sformatf("v%0d_led4", i), bus.LED4, 1);
            tone = 1'b0;
            wait_ticks(tbl[i].len - tbl[i].len / 2);
            chk($sformatf("v%0d_note", i), bus.NOTE, tbl[i].exp_note);
            chk($sformatf("v%0d_leds", i), led_act(), led_exp(tbl[i].exp_note));
            chk($sformatf("v%0d_chg", i), chg_cnt - chg_base, tbl[i].exp_chg);
            chk($sformatf("v%0d_note_tol3", i), bus3.NOTE, tbl[i].exp_note3);
        end

        // Lock on note 2, then silence: NOTE drops exactly TIMEOUT ticks after the last edge.
        period(136);
        period(136);
        chg_base = chg_cnt;
        period(136);
        chk("to_lock_note", bus.NOTE, 2);
        chk("to_lock_chg", chg_cnt - chg_base, 1);
        t_lock = last_chg_cyc;
        wait_ticks(60);
        chk("to_before_note", bus.NOTE, 2);
        wait_ticks(10);
        chk("to_after_note", bus.NOTE, 0);
        chk("to_after_leds", led_act(), 0);
        chk("to_chg", chg_cnt - chg_base, 2);
        chk("to_spacing", last_chg_cyc - t_lock, TIMEOUT * CLK_DIV);

        // Re-acquisition from IDLE takes three fresh edges.
        period(152);
        period(152);
        chk("reacq_2edges", bus.NOTE, 0);
        period(152);
        chk("reacq_3edges", bus.NOTE, 1);

        // Lock on note 4, then a one-cycle reset.
        period(115);
        period(115);
        period(115);
        chk("ml_lock_note", bus.NOTE, 4);
        chk("ml_lock_led3", bus.LED3, 1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        chk("ml_rst_note", bus.NOTE, 0);
        chk("ml_rst_led3", bus.LED3, 0);
        chk("ml_rst_valid", bus.NOTE_VALID, 0);
        period(115);
        period(115);
        chk("ml_reacq_2edges", bus.NOTE, 0);
        period(115);
        chk("ml_reacq_3edges", bus.NOTE, 4);
        chk("ml_reacq_led3", bus.LED3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
